onehot_encoder_1024x10_seq: RTL and testbench
=============================================

# onehot_encoder_1024x10_seq

Multi-cycle one-hot-to-binary encoder that consumes the 1024-bit one-hot output of the 10-to-1024 decoder and recovers the 10-bit index. It also flags zero-hot and multi-hot vectors. It is the downstream checker/consumer stage of the decoder. It scans the captured vector in fixed-width chunks, so no 1024-input priority tree sits in one cycle.

## Interface
Parameters:
- N_IN, 1024, width of one-hot input vector; power of 2.
- W_OUT, 10, index width; equals log2(N_IN).
- CHUNK, 64, bits examined per scan cycle; power of 2, divides N_IN.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request to capture y and begin a scan; honoured only when busy=0.
- y  input  N_IN  one-hot vector from the decoder, bit i = decoded value i.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse: results updated this cycle.
- idx  output  W_OUT  encoded index; lowest set bit position when err_multi.
- valid  output  1  exactly one bit of y was set.
- err_none  output  1  no bit of y was set (e.g. decoder En=0).
- err_multi  output  1  two or more bits of y were set.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: on start=1, latch y into an internal shadow register. Also clear chunk counter k, hit count (2-bit, saturating at 2) and first-hit index. Go to SCAN. start=0: stay.
- SCAN: each cycle examine shadow bits [k*CHUNK +: CHUNK]:
  - Count ones in the chunk, saturating at 2, and add to the hit count (saturating at 2).
  - If this is the first chunk containing a set bit, record first-hit index = k*CHUNK + lowest set position in chunk.
  - k is log2(N_IN/CHUNK) bits wide. When k = N_IN/CHUNK−1, go to DONE; otherwise k+1.
- DONE: register the results and pulse done, then return to IDLE:
  - hits=1: valid=1, err_none=0, err_multi=0, idx=first-hit.
  - hits=0: valid=0, err_none=1, err_multi=0, idx=0.
  - hits=2: valid=0, err_none=0, err_multi=1, idx=first-hit (lowest set bit overall).
- Exactly one of valid/err_none/err_multi is 1 after any completed scan. All three are 0 only after reset, before the first done.
- y is sampled only in the start cycle. Changes to y during SCAN/DONE have no effect.
- start while busy=1, including the DONE cycle, is ignored and not queued.
- Outputs idx/valid/err_none/err_multi hold their values until the next DONE.

## Timing
- Reset (rst_n=0 at a rising edge): state=IDLE, k=0, busy=0, done=0, idx=0, valid=0, err_none=0, err_multi=0, shadow cleared.
- Reset mid-SCAN or in DONE aborts the scan: no done pulse, and all outputs take reset values.
- Start sampled at edge E0: busy=1 from E0.
- SCAN occupies N_IN/CHUNK cycles (16 at defaults), processing chunks 0..15 at edges E1..E16.
- Edge E17: state=DONE; done=1 and results valid in the same cycle.
- Edge E18: state=IDLE, busy=0, done=0. The earliest next accepted start is sampled at E18.
- Latency start→done = N_IN/CHUNK + 1 cycles (17 at defaults). Throughput is one scan per 18 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then hold idle: busy, done, idx, valid, err_none, err_multi all 0. Assert rst_n=0 at cycle 5 of a scan → no done, and outputs return to 0.
- y=1<<3, start one cycle → done exactly 17 cycles later, valid=1, idx=3, errors 0. Repeat with y=1<<2 → idx=2. Repeat with y=1<<1023 → idx=1023 (last chunk).
- y=0 (decoder En=0), start → done, err_none=1, valid=0, err_multi=0, idx=0.
- y bits 2 and 3 set → err_multi=1, idx=2. y bits 700 and 5 set (different chunks) → err_multi=1, idx=5.
- y=1<<64 then start. During SCAN drive y=1<<9 and pulse start at E3 and in the DONE cycle → single done, idx=64, and no second scan begins.
- Back-to-back: start at E18 with y=1<<512 → second done at E35, idx=512, valid=1. First results held at idx=64 until E35.

Source files
------------

// File: rtl/onehot_encoder_1024x10_seq.sv
// onehot_encoder_1024x10_seq: chunked multi-cycle one-hot to binary encoder with zero/multi-hot flags
module onehot_encoder_1024x10_seq #(
  parameter int N_IN  = 1024,
  parameter int W_OUT = 10,
  parameter int CHUNK = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N_IN-1:0]  y,
  output logic             busy,
  output logic             done,
  output logic [W_OUT-1:0] idx,
  output logic             valid,
  output logic             err_none,
  output logic             err_multi
);
  localparam int NC = N_IN / CHUNK;
  localparam int KW = $clog2(NC);
  localparam int PW = $clog2(CHUNK);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t           state;
  logic [N_IN-1:0]  shadow;
  logic [KW-1:0]    k;
  logic [1:0]       hits;
  logic [W_OUT-1:0] first;
  logic [CHUNK-1:0] chunk;
  logic [1:0]       c_cnt;
  logic [PW-1:0]    c_pos;
  logic [2:0]       sum;
  assign busy = state != IDLE;
  // Downward walk leaves c_pos at the lowest set bit; count saturates at 2.
  always_comb begin
    chunk = shadow[k*CHUNK +: CHUNK];
    c_cnt = '0;
    c_pos = '0;
    for (int i = CHUNK - 1; i >= 0; i--)
      if (chunk[i]) begin
        c_pos = PW'(i);
        c_cnt = (c_cnt == 2'd2) ? 2'd2 : c_cnt + 2'd1;
      end
    sum = {1'b0, hits} + {1'b0, c_cnt};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      shadow    <= '0;
      k         <= '0;
      hits      <= '0;
      first     <= '0;
      done      <= 1'b0;
      idx       <= '0;
      valid     <= 1'b0;
      err_none  <= 1'b0;
      err_multi <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          shadow <= y;
          k      <= '0;
          hits   <= '0;
          first  <= '0;
          state  <= SCAN;
        end
        SCAN: begin
          hits <= (sum[2] | sum[1]) ? 2'd2 : sum[1:0];
          if (hits == 2'd0 && c_cnt != 2'd0) first <= W_OUT'({k, c_pos});
          k <= k + 1'b1;
          if (k == KW'(NC - 1)) state <= DONE;
        end
        DONE: begin
          done      <= 1'b1;
          idx       <= (hits == 2'd0) ? '0 : first;
          valid     <= hits == 2'd1;
          err_none  <= hits == 2'd0;
          err_multi <= hits == 2'd2;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_onehot_encoder_1024x10_seq.sv
// tb_onehot_encoder_1024x10_seq: randomized and directed checks against a popcount-based reference model
module tb_onehot_encoder_1024x10_seq;
  logic clk, rst_n, start;
  logic [1023:0] y;
  logic busy, done, valid, err_none, err_multi;
  logic [9:0] idx;
  int tests = 0;
  int fails = 0;
  typedef struct packed {logic [9:0] idx; logic valid; logic en; logic em;} res_t;
  onehot_encoder_1024x10_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .y(y), .busy(busy), .done(done),
    .idx(idx), .valid(valid), .err_none(err_none), .err_multi(err_multi)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [1023:0] bit_at(input int i);
    logic [1023:0] t;
    t = '0;
    t[i] = 1'b1;
    return t;
  endfunction
  function automatic res_t model(input logic [1023:0] v);
    res_t r;
    int cnt;
    int low;
    cnt = $countones(v);
    low = 0;
    for (int i = 1023; i >= 0; i--) if (v[i]) low = i;
    r.idx = (cnt == 0) ? 10'd0 : 10'(low);
    r.valid = cnt == 1;
    r.en = cnt == 0;
    r.em = cnt >= 2;
    return r;
  endfunction
  function automatic res_t cur();
    return {idx, valid, err_none, err_multi};
  endfunction
  task automatic run_check(input logic [1023:0] v, input string name);
    res_t e;
    int lat;
    e = model(v);
    lat = -1;
    y = v; start = 1'b1; tick; start = 1'b0;
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL %s busy_after_start got=%b want=1", name, busy); end
    y = {32{$urandom}};
    for (int c = 1; c <= 40 && lat < 0; c++) begin tick; if (done === 1'b1) lat = c; end
    tests++;
    if (lat != 17) begin fails++; $display("FAIL %s latency got=%0d want=17", name, lat); end
    tests++;
    if (cur() !== e)
      begin fails++; $display("FAIL %s result got idx=%0d v=%b n=%b m=%b want idx=%0d v=%b n=%b m=%b", name, idx, valid, err_none, err_multi, e.idx, e.valid, e.en, e.em); end
    tick;
    tests++;
    if ({done, busy} !== 2'b00 || cur() !== e)
      begin fails++; $display("FAIL %s hold got done=%b busy=%b idx=%0d want done=0 busy=0 idx=%0d", name, done, busy, idx, e.idx); end
  endtask
  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; y = '0;
    repeat (3) tick;
    tests++;
    if ({busy, done, idx, valid, err_none, err_multi} !== 15'd0)
      begin fails++; $display("FAIL reset_state got busy=%b done=%b idx=%0d v=%b n=%b m=%b want all 0", busy, done, idx, valid, err_none, err_multi); end
    rst_n = 1'b1;
    repeat (5) tick;
    tests++;
    if ({busy, done, idx, valid, err_none, err_multi} !== 15'd0)
      begin fails++; $display("FAIL idle_hold got busy=%b done=%b idx=%0d want all 0", busy, done, idx); end
  endtask
  task automatic test_directed;
    logic [1023:0] v;
    run_check(bit_at(3), "onehot3");
    run_check(bit_at(2), "onehot2");
    run_check(bit_at(1023), "onehot1023");
    run_check('0, "zerohot");
    v = bit_at(2) | bit_at(3);
    run_check(v, "multi_2_3");
    v = bit_at(700) | bit_at(5);
    run_check(v, "multi_700_5");
  endtask
  task automatic test_ignore_start;
    int lat;
    int extra;
    lat = -1;
    extra = 0;
    y = bit_at(64); start = 1'b1; tick; start = 1'b0;
    y = bit_at(9);
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      start = (c == 3 || c == 17);
      tick;
      start = 1'b0;
      if (done === 1'b1) lat = c;
    end
    tests++;
    if (lat != 17) begin fails++; $display("FAIL ignore latency got=%0d want=17", lat); end
    tests++;
    if ({idx, valid, err_none, err_multi} !== {10'd64, 3'b100})
      begin fails++; $display("FAIL ignore result got idx=%0d v=%b n=%b m=%b want idx=64 v=1", idx, valid, err_none, err_multi); end
    repeat (25) begin tick; if (done !== 1'b0 || busy !== 1'b0) extra++; end
    tests++;
    if (extra != 0) begin fails++; $display("FAIL ignore extra_scan got=%0d busy/done cycles want=0", extra); end
  endtask
  task automatic test_back_to_back;
    int lat;
    int lat2;
    int held_bad;
    lat = -1; lat2 = -1; held_bad = 0;
    y = bit_at(64); start = 1'b1; tick; start = 1'b0;
    for (int c = 1; c <= 40 && lat < 0; c++) begin tick; if (done === 1'b1) lat = c; end
    tests++;
    if (lat != 17) begin fails++; $display("FAIL b2b first_latency got=%0d want=17", lat); end
    y = bit_at(512); start = 1'b1; tick; start = 1'b0;
    tests++;
    if ({busy, done} !== 2'b10) begin fails++; $display("FAIL b2b accept got busy=%b done=%b want busy=1 done=0", busy, done); end
    for (int c = 19; c <= 60 && lat2 < 0; c++) begin
      tick;
      if (done === 1'b1) lat2 = c;
      else if (idx !== 10'd64 || valid !== 1'b1) held_bad++;
    end
    tests++;
    if (lat2 != 35) begin fails++; $display("FAIL b2b second_done_edge got=%0d want=35", lat2); end
    tests++;
    if (held_bad != 0) begin fails++; $display("FAIL b2b held_results got=%0d bad cycles want=0", held_bad); end
    tests++;
    if ({idx, valid, err_none, err_multi} !== {10'd512, 3'b100})
      begin fails++; $display("FAIL b2b second_result got idx=%0d v=%b want idx=512 v=1", idx, valid); end
    tick;
  endtask
  task automatic test_random;
    logic [1023:0] v;
    for (int n = 0; n < 12; n++) begin
      v = '0;
      case ($urandom_range(0, 3))
        0: v = '0;
        1: v = bit_at($urandom_range(0, 1023));
        2: repeat ($urandom_range(2, 4)) v = v | bit_at($urandom_range(0, 1023));
        default: v = {32{$urandom}} & {32{$urandom}};
      endcase
      run_check(v, "random");
    end
  endtask
  task automatic test_reset_mid_scan;
    int seen;
    seen = 0;
    y = bit_at(3); start = 1'b1; tick; start = 1'b0;
    repeat (4) tick;
    rst_n = 1'b0;
    tick;
    tests++;
    if ({busy, done, idx, valid, err_none, err_multi} !== 15'd0)
      begin fails++; $display("FAIL midreset state got busy=%b done=%b idx=%0d v=%b n=%b m=%b want all 0", busy, done, idx, valid, err_none, err_multi); end
    rst_n = 1'b1;
    repeat (25) begin tick; if (done !== 1'b0) seen++; end
    tests++;
    if (seen != 0 || {busy, idx, valid, err_none, err_multi} !== 14'd0)
      begin fails++; $display("FAIL midreset no_done got=%0d pulses idx=%0d want 0 pulses idx=0", seen, idx); end
  endtask
  initial begin
    test_reset;
    test_directed;
    test_ignore_start;
    test_back_to_back;
    test_random;
    test_reset_mid_scan;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
